// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: op encodings, compare codes, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_arb_pkg;

  // Per-requester operation encodings carried on req_op
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // Result codes returned by a signed compare
  localparam int CMP_EQ = 0;
  localparam int CMP_GT = 2;
  localparam int CMP_LT = 4;

  // Arbiter sequencing: grant, execute on the shared adder, hold response
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Requester-id width, never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_arbiter_universal_adder.sv
// Plain ripple-free DATAWIDTH adder with carry-in; the single shared arithmetic resource.
// Latency: combinational.
// Backpressure: none; carry-out is not produced (arithmetic is modulo 2^DATAWIDTH).
module universal_adder #(
  parameter int DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] b_i,
  input  logic                 cin_i,
  output logic [DATAWIDTH-1:0] sum_o
);

  // Subtraction is done by the caller passing ~b with carry-in set
  assign sum_o = a_i + b_i + {{(DATAWIDTH-1){1'b0}}, cin_i};

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one universal_adder among NREQ requesters, one op in flight.
// Latency: handshake in cycle C, resp_valid in C+2; next grant possible at C+3.
// Backpressure: RESP holds data/id until resp_ready; all requesters see req_ready=0 meanwhile.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int DATAWIDTH = 32,
  parameter  int NREQ      = 3,
  localparam int IDW       = id_width(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*DATAWIDTH-1:0] req_a,
  input  logic [NREQ*DATAWIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]         req_op,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATAWIDTH-1:0]      resp_data,
  output logic [IDW-1:0]            resp_id
);

  localparam int MSB = DATAWIDTH - 1;

  arb_state_e           state_q;
  logic [IDW-1:0]       rr_ptr_q;
  logic [IDW-1:0]       rr_ptr_d;

  // Latched operation, owned by the arbiter from handshake until response
  logic [DATAWIDTH-1:0] a_q;
  logic [DATAWIDTH-1:0] b_q;
  logic [1:0]           op_q;
  logic [IDW-1:0]       id_q;

  // Registered response
  logic                 resp_valid_q;
  logic [DATAWIDTH-1:0] resp_data_q;
  logic [IDW-1:0]       resp_id_q;

  // Grant selection
  logic [NREQ-1:0]      grant_oh;
  logic [IDW-1:0]       grant_id;
  logic                 grant_found;
  logic [DATAWIDTH-1:0] a_sel;
  logic [DATAWIDTH-1:0] b_sel;
  logic [1:0]           op_sel;

  // Shared adder datapath
  logic [DATAWIDTH-1:0] add_b;
  logic                 add_cin;
  logic [DATAWIDTH-1:0] add_sum;
  logic                 cmp_lt;
  logic [DATAWIDTH-1:0] result_d;

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    grant_oh    = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    idx         = 0;
    idx_w       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      idx_w = IDW'(idx);
      if (!grant_found && req_valid[idx_w]) begin
        grant_found     = 1'b1;
        grant_id        = idx_w;
        grant_oh[idx_w] = 1'b1;
      end
    end
  end

  // Operand mux for the grantee; pointer advances past it and wraps after NREQ-1
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = OP_ADD;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id == IDW'(k)) begin
        a_sel  = req_a[k*DATAWIDTH +: DATAWIDTH];
        b_sel  = req_b[k*DATAWIDTH +: DATAWIDTH];
        op_sel = req_op[k*2 +: 2];
      end
    end
    rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // Grants are only offered from IDLE and are suppressed while reset is asserted
  assign req_ready = (state_q == IDLE && !rst) ? grant_oh : '0;

  // Adder is fed only from latched operands; sub/cmp use two's complement of b
  always_comb begin
    add_cin = (op_q != OP_ADD);
    add_b   = (op_q == OP_ADD) ? b_q : ~b_q;
  end

  universal_adder #(
    .DATAWIDTH(DATAWIDTH)
  ) u_adder (
    .a_i  (a_q),
    .b_i  (add_b),
    .cin_i(add_cin),
    .sum_o(add_sum)
  );

  // Result formatting; signed less-than looks at the sign bits first so overflow is harmless
  always_comb begin
    cmp_lt   = (a_q[MSB] ^ b_q[MSB]) ? a_q[MSB] : add_sum[MSB];
    result_d = '0;
    case (op_q)
      OP_ADD, OP_SUB: result_d = add_sum;
      OP_CMP: begin
        if (add_sum == '0) begin
          result_d = DATAWIDTH'(CMP_EQ);
        end else if (cmp_lt) begin
          result_d = DATAWIDTH'(CMP_LT);
        end else begin
          result_d = DATAWIDTH'(CMP_GT);
        end
      end
      default: result_d = '0;
    endcase
  end

  // Control FSM: latch on handshake, execute for one cycle, hold response until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Any grant offered here is a handshake, since only valid requesters are granted
          if (grant_found) begin
            a_q      <= a_sel;
            b_q      <= b_sel;
            op_q     <= op_sel;
            id_q     <= grant_id;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          resp_data_q  <= result_d;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: arithmetic, round-robin order, backpressure, mid-op reset.
// Latency: expects resp_valid two cycles after the grant cycle.
// Backpressure: exercises resp_ready low for ten cycles while another requester waits.
module tb_adder_arbiter;
  import adder_arb_pkg::*;

  localparam int DW = 32;
  localparam int NR = 3;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR*2-1:0]  req_op;
  logic             resp_valid;
  logic             resp_ready;
  logic [DW-1:0]    resp_data;
  logic [IW-1:0]    resp_id;

  int checks = 0;
  int errors = 0;

  adder_arbiter #(
    .DATAWIDTH(DW),
    .NREQ     (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_id   (resp_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [1:0] op);
    for (int k = 0; k < NR; k++) begin
      if (k == id) begin
        req_a[k*DW +: DW] = a;
        req_b[k*DW +: DW] = b;
        req_op[k*2 +: 2]  = op;
      end
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int i);
    return NR'(1 << i);
  endfunction

  // One isolated operation from requester id; starts at an IDLE negedge, ends in RESP
  task automatic do_op(input string tag, input int id, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [1:0] op, input logic [DW-1:0] exp);
    @(negedge clk);
    set_req(id, a, b, op);
    req_valid = onehot(id);
    #1 chk({tag, "_grant"}, 64'(req_ready), 64'(onehot(id)));
    @(negedge clk);
    req_valid = '0;
    #1 chk({tag, "_exec_rdy"}, 64'(req_ready), 64'd0);
    chk({tag, "_exec_vld"}, 64'(resp_valid), 64'd0);
    @(negedge clk);
    #1 chk({tag, "_vld"}, 64'(resp_valid), 64'd1);
    chk({tag, "_data"}, 64'(resp_data), 64'(exp));
    chk({tag, "_id"}, 64'(resp_id), 64'(id));
    chk({tag, "_resp_rdy"}, 64'(req_ready), 64'd0);
  endtask

  logic [DW-1:0] rot_exp [NR];

  initial begin
    rst        = 1'b1;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b1;

    // Reset state; grants are suppressed even with all requesters valid
    repeat (2) @(negedge clk);
    #1 chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);

    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    #1 chk("idle_no_valid", 64'(req_ready), 64'd0);

    // Arithmetic and compare encodings
    do_op("add_5_7",  1, 32'd5,          32'd7,          OP_ADD, 32'd12);
    do_op("sub_3_5",  2, 32'd3,          32'd5,          OP_SUB, 32'hFFFF_FFFE);
    do_op("cmp_ovf",  0, 32'h8000_0000,  32'd1,          OP_CMP, 32'd4);
    do_op("cmp_eq",   1, 32'd7,          32'd7,          OP_CMP, 32'd0);
    do_op("cmp_gt",   2, 32'd1,          32'hFFFF_FFFF,  OP_CMP, 32'd2);
    do_op("cmp_lt",   0, 32'd2,          32'd9,          OP_CMP, 32'd4);
    do_op("op_rsv",   1, 32'd5,          32'd7,          OP_RSV, 32'd0);
    do_op("add_wrap", 2, 32'hFFFF_FFFF,  32'd2,          OP_ADD, 32'd1);

    // Round robin with everyone valid from reset: 0,1,2,0,1
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rr_rst_vld", 64'(resp_valid), 64'd0);
    set_req(0, 32'd10, 32'd20, OP_ADD);
    set_req(1, 32'd100, 32'd1, OP_SUB);
    set_req(2, 32'hFFFF_FFFB, 32'd3, OP_CMP);
    rot_exp[0] = 32'd30;
    rot_exp[1] = 32'd99;
    rot_exp[2] = 32'd4;
    req_valid  = '1;
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
      if (g > 0) @(negedge clk);
      #1 chk("rr_grant", 64'(req_ready), 64'(onehot(g % NR)));
      @(negedge clk);
      #1 chk("rr_exec_rdy", 64'(req_ready), 64'd0);
      @(negedge clk);
      #1 chk("rr_vld", 64'(resp_valid), 64'd1);
      chk("rr_id", 64'(resp_id), 64'(g % NR));
      chk("rr_data", 64'(resp_data), 64'(rot_exp[g % NR]));
    end

    // Backpressure: requester 1 served, requester 0 waits behind a stalled response
    @(negedge clk);
    req_valid  = 3'b010;
    resp_ready = 1'b0;
    #1 chk("bp_grant1", 64'(req_ready), 64'b010);
    @(negedge clk);
    req_valid = 3'b001;
    #1 chk("bp_exec_rdy", 64'(req_ready), 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1 chk("bp_hold_vld", 64'(resp_valid), 64'd1);
      chk("bp_hold_data", 64'(resp_data), 64'd99);
      chk("bp_hold_id", 64'(resp_id), 64'd1);
      chk("bp_hold_rdy", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1 chk("bp_release_vld", 64'(resp_valid), 64'd1);
    @(negedge clk);
    #1 chk("bp_idle_vld", 64'(resp_valid), 64'd0);
    chk("bp_next_grant0", 64'(req_ready), 64'b001);

    // Reset during EXEC: operation dropped, pointer back to 0
    @(negedge clk);
    req_valid = '1;
    rst       = 1'b1;
    #1 chk("exec_rst_vld", 64'(resp_valid), 64'd0);
    chk("exec_rst_rdy", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("exec_rst_noresp", 64'(resp_valid), 64'd0);
    end
    @(negedge clk);
    req_valid = '1;
    #1 chk("exec_rst_rr0", 64'(req_ready), 64'b001);

    // Reset during RESP: response withdrawn immediately, pointer back to 0
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1 chk("resp_pre_vld", 64'(resp_valid), 64'd1);
    chk("resp_pre_data", 64'(resp_data), 64'd30);
    rst = 1'b1;
    #1 chk("resp_rst_vld", 64'(resp_valid), 64'd0);
    chk("resp_rst_data", 64'(resp_data), 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '1;
    #1 chk("resp_rst_rr0", 64'(req_ready), 64'b001);
    chk("resp_rst_idle", 64'(resp_valid), 64'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one `universal_adder` among NREQ requesters (IFU next-PC, EXU ALU, LSU address generation) through per-requester valid/ready handshakes. Grants are round-robin, and one operation is in flight at a time. Each operation's operands are latched, executed on the shared adder, and returned in a registered response tagged with the requester id. It sits between the pipeline stages and the single adder instance, and replaces per-stage adders.

## Interface
- `DATAWIDTH`, 32, operand/result width
- `NREQ`, 3, number of requesters (≥2); `IDW` = max(1, $clog2(NREQ)), derived
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  requester i has an operation pending
- `req_ready`  out  NREQ  one-hot grant; handshake when valid[i] & ready[i]
- `req_a`  in  NREQ*DATAWIDTH  operand A, requester i at bits [i*DATAWIDTH +: DATAWIDTH]
- `req_b`  in  NREQ*DATAWIDTH  operand B, same packing
- `req_op`  in  NREQ*2  op per requester: 00 add, 01 sub, 10 signed compare, 11 reserved
- `resp_valid`  out  1  result available
- `resp_ready`  in  1  consumer accepts result
- `resp_data`  out  DATAWIDTH  result
- `resp_id`  out  IDW  index of requester that issued the op

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant the first requester with valid set, scanning from `rr_ptr` upward, modulo NREQ.
  - Drive `req_ready` one-hot to the grantee; all zero if no valid.
  - On handshake: latch A, B, op and id; set `rr_ptr` = grantee+1 mod NREQ; go to EXEC.
- EXEC: adder inputs come from latched operands only.
  - add: a+b.
  - sub: a + (~b+1).
  - cmp: a + (~b+1), then encode the result: equal → 0; a>b → 2; a<b → 4.
  - Signed compare: lt = (a[MSB]^b[MSB]) ? a[MSB] : diff[MSB], which is overflow-correct.
  - op 11: result 0.
  - Register the result into `resp_data` and the latched id into `resp_id`; go to RESP.
- RESP: `resp_valid`=1. `resp_data` and `resp_id` are held stable until `resp_ready`=1, then go to IDLE and drop `resp_valid` the next cycle.
- `req_ready` is 0 in EXEC and RESP. No new grant is made until the FSM returns to IDLE.
- Requesters must hold valid and operands stable until their handshake. Dropping valid before the handshake is permitted; the grant then moves on combinationally.
- Adder arithmetic is modulo 2^DATAWIDTH. Carry-out is discarded.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `resp_valid`=0, `resp_data`=0, `resp_id`=0.
- `req_ready` is forced to all zero while `rst` is high.
- Latency: handshake in cycle C → EXEC in C+1 → `resp_valid` high in C+2.
- Minimum issue interval is 3 cycles, with `resp_ready` tied high.
- `resp_ready` high during the first RESP cycle → IDLE at C+3, where a new grant is possible.
- Backpressure: RESP persists indefinitely while `resp_ready`=0. Other requesters stall, and valid-but-ungranted requesters are never lost.
- Simultaneous requests: exactly one is granted per IDLE cycle. With all NREQ valid continuously, grants rotate 0,1,2,0,…
- Pointer wrap: a grant to NREQ-1 sets `rr_ptr` to 0.
- Reset mid-operation (EXEC or RESP): the operation is discarded, no response is issued, and the FSM returns to IDLE.
- `resp_ready` asserted outside RESP is ignored.

## Structure
- Shared package `adder_arb_pkg` holds:
  - op encodings `OP_ADD`=2'b00, `OP_SUB`=2'b01, `OP_CMP`=2'b10;
  - compare codes `CMP_EQ`=0, `CMP_GT`=2, `CMP_LT`=4;
  - FSM state enum.
- One sub-module: the existing `universal_adder` (`DATAWIDTH` passed through), instantiated once.
- Round-robin grant logic stays inline. No further sub-modules.

## Test plan
- Single add: requester 1 issues 5+7 in cycle 0, `resp_ready`=1 → `resp_valid` at cycle 2, `resp_data`=12, `resp_id`=1, `req_ready`=0 in cycles 1–2.
- Sub and compare:
  - 3−5 → 0xFFFFFFFE.
  - cmp(0x80000000, 1) → 4 (signed lt, overflow case).
  - cmp(7, 7) → 0.
  - cmp(1, 0xFFFFFFFF) → 2.
  - op 11 → 0.
- All three requesters valid continuously from reset → grant order 0,1,2,0,1; each response carries the matching id and result.
- `resp_ready` held low for 10 cycles with requester 0 valid → `resp_valid`, `resp_data` and `resp_id` stable, `req_ready` stays 0; release → IDLE next cycle, then requester 0 granted.
- Assert `rst` during EXEC, and separately during RESP → `resp_valid`=0 and state IDLE immediately; the pending op never responds; `rr_ptr`=0, so requester 0 wins the first grant after reset.
